// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined control path: branch/jump/result/PC/forward codes,
// the bubble fill value and the branch-condition helper used in the E stage.
package ctrl_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b011;
    localparam logic [2:0] BR_BGE  = 3'b100;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_JAL  = 2'b01;
    localparam logic [1:0] JMP_JALR = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // A bubble is an all-zero stage word: no write, no branch, rd = x0.
    localparam logic BUBBLE_BIT = 1'b0;

    function automatic logic branch_taken(input logic [2:0] branch,
                                          input logic       zero,
                                          input logic       lt);
        case (branch)
            BR_BEQ:  return zero;
            BR_BNE:  return !zero;
            BR_BLT:  return lt;
            BR_BGE:  return !lt;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Control-path bundle between the decode controller / datapath and ctrl_pipe.
// Perf counter signals exist only when CTRL_PIPE_PERF_EN is defined.
interface ctrl_pipe_if #(
    parameter int REG_W      = 5,
    parameter int ALU_CTRL_W = 3
);
    logic                  regWriteD;
    logic                  memWriteD;
    logic                  ALUSrcD;
    logic                  luiD;
    logic [1:0]            resultSrcD;
    logic [1:0]            jumpD;
    logic [2:0]            branchD;
    logic [ALU_CTRL_W-1:0] aluCtrlD;
    logic [REG_W-1:0]      rs1D;
    logic [REG_W-1:0]      rs2D;
    logic [REG_W-1:0]      rdD;
    logic                  zeroE;
    logic                  ltE;

    logic                  ALUSrcE;
    logic                  luiE;
    logic [ALU_CTRL_W-1:0] aluCtrlE;
    logic [1:0]            PCSrcE;
    logic [1:0]            forwardAE;
    logic [1:0]            forwardBE;
    logic                  memWriteM;
    logic [1:0]            resultSrcM;
    logic                  regWriteW;
    logic [1:0]            resultSrcW;
    logic [REG_W-1:0]      rdW;
    logic                  stallF;
    logic                  stallD;
    logic                  flushD;
`ifdef CTRL_PIPE_PERF_EN
    logic [31:0]           stallCnt;
    logic [31:0]           flushCnt;
`endif

    modport master (
        output regWriteD, memWriteD, ALUSrcD, luiD, resultSrcD, jumpD, branchD,
               aluCtrlD, rs1D, rs2D, rdD, zeroE, ltE,
        input  ALUSrcE, luiE, aluCtrlE, PCSrcE, forwardAE, forwardBE, memWriteM,
               resultSrcM, regWriteW, resultSrcW, rdW, stallF, stallD, flushD
`ifdef CTRL_PIPE_PERF_EN
        , input stallCnt, flushCnt
`endif
    );

    modport slave (
        input  regWriteD, memWriteD, ALUSrcD, luiD, resultSrcD, jumpD, branchD,
               aluCtrlD, rs1D, rs2D, rdD, zeroE, ltE,
        output ALUSrcE, luiE, aluCtrlE, PCSrcE, forwardAE, forwardBE, memWriteM,
               resultSrcM, regWriteW, resultSrcW, rdW, stallF, stallD, flushD
`ifdef CTRL_PIPE_PERF_EN
        , output stallCnt, flushCnt
`endif
    );

endinterface

// File: rtl/ctrl_pipe_hazard_detect.sv
// Combinational hazard unit: load-use stall, control-hazard flush and
// E-stage operand forwarding selects.
module hazard_detect
    import ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs1D,
    input  logic [REG_W-1:0] rs2D,
    input  logic [REG_W-1:0] rs1E,
    input  logic [REG_W-1:0] rs2E,
    input  logic [REG_W-1:0] rdE,
    input  logic [REG_W-1:0] rdM,
    input  logic [REG_W-1:0] rdW,
    input  logic [1:0]       resultSrcE,
    input  logic             regWriteM,
    input  logic             regWriteW,
    input  logic [1:0]       PCSrcE,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             flushE,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE
);

    logic load_use;
    logic ctrl_hazard;

    // The newest producer (M) wins over the older one (W); x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs);
        if (regWriteM && (rdM != '0) && (rdM == rs)) return FWD_M;
        if (regWriteW && (rdW != '0) && (rdW == rs)) return FWD_W;
        return FWD_RF;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        load_use    = 1'b0;
        ctrl_hazard = 1'b0;
        stallF      = 1'b0;
        stallD      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        forwardAE   = FWD_RF;
        forwardBE   = FWD_RF;

        load_use    = (resultSrcE == RES_MEM) && (rdE != '0) &&
                      ((rdE == rs1D) || (rdE == rs2D));
        ctrl_hazard = (PCSrcE != PC_PLUS4);

        stallF    = load_use;
        stallD    = load_use;
        flushD    = ctrl_hazard;
        flushE    = load_use | ctrl_hazard;
        forwardAE = fwd_sel(rs1E);
        forwardBE = fwd_sel(rs2E);
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Carries the decoded control word through the E/M/W stage registers and resolves
// branches in E. Optional stall/flush counters are enabled by CTRL_PIPE_PERF_EN.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int ALU_CTRL_W = 3
) (
    input  logic       clk,
    input  logic       rst,
    ctrl_pipe_if.slave bus
);

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_write;
        logic                  alu_src;
        logic                  lui;
        logic [1:0]            result_src;
        logic [1:0]            jump;
        logic [2:0]            branch;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic [REG_W-1:0]      rs1;
        logic [REG_W-1:0]      rs2;
        logic [REG_W-1:0]      rd;
    } e_stage_t;

    typedef struct packed {
        logic             reg_write;
        logic             mem_write;
        logic [1:0]       result_src;
        logic [REG_W-1:0] rd;
    } m_stage_t;

    typedef struct packed {
        logic             reg_write;
        logic [1:0]       result_src;
        logic [REG_W-1:0] rd;
    } w_stage_t;

    localparam e_stage_t E_BUBBLE = {$bits(e_stage_t){BUBBLE_BIT}};
    localparam m_stage_t M_BUBBLE = {$bits(m_stage_t){BUBBLE_BIT}};
    localparam w_stage_t W_BUBBLE = {$bits(w_stage_t){BUBBLE_BIT}};

    e_stage_t   e_q, e_d;
    m_stage_t   m_q, m_d;
    w_stage_t   w_q, w_d;
    logic [1:0] pc_src;
    logic       stall;
    logic       stall_d_unused;
    logic       flush_d;
    logic       flush_e;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    always_comb begin
        pc_src = PC_PLUS4;
        if (e_q.jump == JMP_JALR) begin
            pc_src = PC_ALU;
        end else if ((e_q.jump == JMP_JAL) ||
                     branch_taken(e_q.branch, bus.zeroE, bus.ltE)) begin
            pc_src = PC_IMM;
        end
    end

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .rs1D       (bus.rs1D),
        .rs2D       (bus.rs2D),
        .rs1E       (e_q.rs1),
        .rs2E       (e_q.rs2),
        .rdE        (e_q.rd),
        .rdM        (m_q.rd),
        .rdW        (w_q.rd),
        .resultSrcE (e_q.result_src),
        .regWriteM  (m_q.reg_write),
        .regWriteW  (w_q.reg_write),
        .PCSrcE     (pc_src),
        .stallF     (stall),
        .stallD     (stall_d_unused),
        .flushD     (flush_d),
        .flushE     (flush_e),
        .forwardAE  (fwd_a),
        .forwardBE  (fwd_b)
    );

    // E is never stalled: a held D instruction re-enters E only after flushE inserts a bubble.
    always_comb begin
        e_d = E_BUBBLE;
        if (!flush_e) begin
            e_d.reg_write  = bus.regWriteD;
            e_d.mem_write  = bus.memWriteD;
            e_d.alu_src    = bus.ALUSrcD;
            e_d.lui        = bus.luiD;
            e_d.result_src = bus.resultSrcD;
            e_d.jump       = bus.jumpD;
            e_d.branch     = bus.branchD;
            e_d.alu_ctrl   = bus.aluCtrlD;
            e_d.rs1        = bus.rs1D;
            e_d.rs2        = bus.rs2D;
            e_d.rd         = bus.rdD;
        end
        m_d = '{reg_write: e_q.reg_write, mem_write: e_q.mem_write,
                result_src: e_q.result_src, rd: e_q.rd};
        w_d = '{reg_write: m_q.reg_write, result_src: m_q.result_src, rd: m_q.rd};
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
        if (rst) begin
            e_q <= E_BUBBLE;
            m_q <= M_BUBBLE;
            w_q <= W_BUBBLE;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign bus.ALUSrcE    = e_q.alu_src;
    assign bus.luiE       = e_q.lui;
    assign bus.aluCtrlE   = e_q.alu_ctrl;
    assign bus.PCSrcE     = pc_src;
    assign bus.forwardAE  = fwd_a;
    assign bus.forwardBE  = fwd_b;
    assign bus.memWriteM  = m_q.mem_write;
    assign bus.resultSrcM = m_q.result_src;
    assign bus.regWriteW  = w_q.reg_write;
    assign bus.resultSrcW = w_q.result_src;
    assign bus.rdW        = w_q.rd;
    assign bus.stallF     = stall;
    assign bus.stallD     = stall_d_unused;
    assign bus.flushD     = flush_d;

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(stall);
        flush_cnt_d = flush_cnt_q + 32'(pc_src != PC_PLUS4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stallCnt = stall_cnt_q;
    assign bus.flushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed vector table, hand sequences and a
// randomized run against an in-flight-instruction reference model.
module tb_ctrl_pipe;

    typedef struct packed {
        logic       rw;
        logic       mw;
        logic       alu_src;
        logic       lui;
        logic [1:0] rsrc;
        logic [1:0] jump;
        logic [2:0] br;
        logic [2:0] alu;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } instr_t;

    typedef struct packed {
        logic       alu_src;
        logic       lui;
        logic [2:0] alu;
        logic [1:0] pc;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       mw;
        logic [1:0] rsm;
        logic       rww;
        logic [1:0] rsw;
        logic [4:0] rdw;
        logic       stf;
        logic       std;
        logic       fd;
    } outs_t;

    typedef struct {
        logic       r;
        instr_t     d;
        logic       z;
        logic       l;
        logic [1:0] pc;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
        logic       fd;
    } vec_t;

    localparam instr_t BUB = '0;

    logic clk;
    logic rst;
    ctrl_pipe_if #(.REG_W(5), .ALU_CTRL_W(3)) bus ();

    ctrl_pipe #(.REG_W(5), .ALU_CTRL_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests  = 0;
    int          failed = 0;
    int          cyc    = 0;
    instr_t      pipe_q[$];          // in-flight instructions: [0]=E, [1]=M, [2]=W
    instr_t      cur_d;
    logic        cur_r, cur_z, cur_l;
    logic        last_stall, last_fd;
    int unsigned m_stall_cnt, m_flush_cnt;
    vec_t        vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic instr_t alu_i(input int rd, input int rs1, input int rs2);
        instr_t i = '0;
        i.rw = 1'b1; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.alu = 3'd2;
        return i;
    endfunction

    function automatic instr_t ld_i(input int rd, input int rs1);
        instr_t i = '0;
        i.rw = 1'b1; i.rsrc = 2'b01; i.alu_src = 1'b1; i.rd = 5'(rd); i.rs1 = 5'(rs1);
        return i;
    endfunction

    function automatic instr_t br_i(input int code, input int rs1, input int rs2);
        instr_t i = '0;
        i.br = 3'(code); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.alu = 3'd1;
        return i;
    endfunction

    function automatic instr_t jalr_i(input int rd, input int rs1);
        instr_t i = '0;
        i.rw = 1'b1; i.rsrc = 2'b10; i.jump = 2'b10; i.alu_src = 1'b1;
        i.rd = 5'(rd); i.rs1 = 5'(rs1);
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.rw      = 1'($urandom_range(0, 1));
        i.mw      = 1'($urandom_range(0, 1));
        i.alu_src = 1'($urandom_range(0, 1));
        i.lui     = 1'($urandom_range(0, 1));
        i.rsrc    = 2'($urandom_range(0, 3));
        i.jump    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
        i.br      = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 4)) : 3'b000;
        i.alu     = 3'($urandom_range(0, 7));
        i.rs1     = 5'($urandom_range(0, 3));
        i.rs2     = 5'($urandom_range(0, 3));
        i.rd      = 5'($urandom_range(0, 3));
        return i;
    endfunction

    // Reference rules, applied to whichever instructions currently occupy E, M and W.
    function automatic logic [1:0] exp_pc(input instr_t e, input logic z, input logic l);
        bit taken;
        taken = (e.br == 3'd1 && z) || (e.br == 3'd2 && !z) ||
                (e.br == 3'd3 && l) || (e.br == 3'd4 && !l);
        if (e.jump == 2'b10) return 2'b10;
        if (e.jump == 2'b01 || taken) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs, input instr_t m, input instr_t w);
        if (m.rw && m.rd != 0 && m.rd == rs) return 2'b10;
        if (w.rw && w.rd != 0 && w.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic outs_t model_outs();
        outs_t  o;
        instr_t e = pipe_q[0];
        instr_t m = pipe_q[1];
        instr_t w = pipe_q[2];
        logic   lu;
        lu        = (e.rsrc == 2'b01) && (e.rd != 0) && (e.rd == cur_d.rs1 || e.rd == cur_d.rs2);
        o.alu_src = e.alu_src;
        o.lui     = e.lui;
        o.alu     = e.alu;
        o.pc      = exp_pc(e, cur_z, cur_l);
        o.fa      = exp_fwd(e.rs1, m, w);
        o.fb      = exp_fwd(e.rs2, m, w);
        o.mw      = m.mw;
        o.rsm     = m.rsrc;
        o.rww     = w.rw;
        o.rsw     = w.rsrc;
        o.rdw     = w.rd;
        o.stf     = lu;
        o.std     = lu;
        o.fd      = (o.pc != 2'b00);
        return o;
    endfunction

    function automatic outs_t act_outs();
        outs_t o;
        o.alu_src = bus.ALUSrcE;
        o.lui     = bus.luiE;
        o.alu     = bus.aluCtrlE;
        o.pc      = bus.PCSrcE;
        o.fa      = bus.forwardAE;
        o.fb      = bus.forwardBE;
        o.mw      = bus.memWriteM;
        o.rsm     = bus.resultSrcM;
        o.rww     = bus.regWriteW;
        o.rsw     = bus.resultSrcW;
        o.rdw     = bus.rdW;
        o.stf     = bus.stallF;
        o.std     = bus.stallD;
        o.fd      = bus.flushD;
        return o;
    endfunction

    task automatic apply(input instr_t d, input logic r, input logic z, input logic l);
        cur_d = d; cur_r = r; cur_z = z; cur_l = l;
        rst            = r;
        bus.regWriteD  = d.rw;
        bus.memWriteD  = d.mw;
        bus.ALUSrcD    = d.alu_src;
        bus.luiD       = d.lui;
        bus.resultSrcD = d.rsrc;
        bus.jumpD      = d.jump;
        bus.branchD    = d.br;
        bus.aluCtrlD   = d.alu;
        bus.rs1D       = d.rs1;
        bus.rs2D       = d.rs2;
        bus.rdD        = d.rd;
        bus.zeroE      = z;
        bus.ltE        = l;
    endtask

    task automatic sample(input bit do_model);
        @(negedge clk);
        if (do_model) begin
            check($sformatf("model@%0d", cyc), 64'(act_outs()), 64'(model_outs()));
`ifdef CTRL_PIPE_PERF_EN
            check($sformatf("stallCnt@%0d", cyc), 64'(bus.stallCnt), 64'(m_stall_cnt));
            check($sformatf("flushCnt@%0d", cyc), 64'(bus.flushCnt), 64'(m_flush_cnt));
`endif
        end
    endtask

    task automatic advance();
        outs_t o = model_outs();
        if (cur_r) begin
            pipe_q.delete();
            repeat (3) pipe_q.push_back(BUB);
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            pipe_q.push_front((o.stf || o.fd) ? BUB : cur_d);
            void'(pipe_q.pop_back());
            m_stall_cnt += o.stf ? 1 : 0;
            m_flush_cnt += o.fd ? 1 : 0;
        end
        last_stall = o.stf && !cur_r;
        last_fd    = o.fd && !cur_r;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input instr_t d, input logic z);
        apply(d, 1'b0, z, 1'b0);
        sample(1);
        advance();
    endtask

    task automatic add_vec(input logic r, input instr_t d, input logic z, input logic l,
                           input logic [1:0] pc, input logic [1:0] fa, input logic [1:0] fb,
                           input logic st, input logic fd);
        vec_t v;
        v.r = r; v.d = d; v.z = z; v.l = l;
        v.pc = pc; v.fa = fa; v.fb = fb; v.st = st; v.fd = fd;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t d;
        logic   r;
        repeat (3) pipe_q.push_back(BUB);
        m_stall_cnt = 0;
        m_flush_cnt = 0;

        // Reset with random D inputs, then idle D and watch W stay empty.
        apply(rand_instr(), 1'b1, 1'b1, 1'b1);
        sample(0);
        advance();
        apply(rand_instr(), 1'b1, 1'b0, 1'b1);
        sample(1);
        check("reset_outs", 64'(act_outs()), 64'd0);
        advance();
        for (int k = 0; k < 3; k++) begin
            apply(BUB, 1'b0, 1'b0, 1'b0);
            sample(1);
            check($sformatf("rst_regWriteW%0d", k), 64'(bus.regWriteW), 64'd0);
            advance();
        end

`ifdef CTRL_PIPE_PERF_EN
        apply(BUB, 1'b1, 1'b0, 1'b0);
        sample(1);
        advance();
        for (int k = 0; k < 3; k++) begin
            step(ld_i(7, 1), 1'b0);
            step(alu_i(13, 2, 7), 1'b0);
            step(alu_i(13, 2, 7), 1'b0);
        end
        for (int k = 0; k < 2; k++) begin
            step(br_i(1, 1, 2), 1'b0);
            step(BUB, 1'b1);
            step(BUB, 1'b0);
        end
        check("perf_stallCnt", 64'(bus.stallCnt), 64'd3);
        check("perf_flushCnt", 64'(bus.flushCnt), 64'd2);
`endif

        // Directed vectors: {rst, D, zeroE, ltE} -> {PCSrcE, forwardAE, forwardBE, stall, flushD}.
        add_vec(0, BUB, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, BUB, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, BUB, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, alu_i(5, 1, 2),  0, 0, 0, 0, 0, 0, 0);
        add_vec(0, alu_i(6, 5, 3),  0, 0, 0, 0, 0, 0, 0);
        add_vec(0, alu_i(9, 1, 1),  0, 0, 0, 2, 0, 0, 0);   // x5 from M
        add_vec(0, alu_i(10, 0, 6), 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, alu_i(0, 1, 1),  0, 0, 0, 0, 1, 0, 0);   // x6 from W
        add_vec(0, alu_i(11, 0, 0), 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, alu_i(12, 1, 1), 0, 0, 0, 0, 0, 0, 0);   // x0 writer in M: no forward
        add_vec(0, alu_i(12, 2, 2), 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, alu_i(15, 12, 0),0, 0, 0, 0, 0, 0, 0);
        add_vec(0, BUB, 0, 0, 0, 2, 0, 0, 0);               // M beats W for x12
        add_vec(0, BUB, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, BUB, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, ld_i(7, 1),      0, 0, 0, 0, 0, 0, 0);
        add_vec(0, alu_i(13, 2, 7), 0, 0, 0, 0, 0, 1, 0);   // load-use stall
        add_vec(0, alu_i(13, 2, 7), 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, BUB, 0, 0, 0, 0, 1, 0, 0);               // load value from W
        add_vec(0, BUB, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, BUB, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, br_i(1, 1, 2),   0, 0, 0, 0, 0, 0, 0);
        add_vec(0, alu_i(14, 0, 0), 1, 0, 1, 0, 0, 0, 1);   // BEQ taken
        add_vec(0, BUB, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, br_i(2, 1, 2),   0, 0, 0, 0, 0, 0, 0);
        add_vec(0, BUB, 1, 0, 0, 0, 0, 0, 0);               // BNE not taken
        add_vec(0, br_i(4, 1, 2),   0, 0, 0, 0, 0, 0, 0);
        add_vec(0, alu_i(14, 0, 0), 0, 0, 1, 0, 0, 0, 1);   // BGE taken
        add_vec(0, jalr_i(1, 0),    0, 0, 0, 0, 0, 0, 0);
        add_vec(0, alu_i(14, 0, 0), 0, 0, 2, 0, 0, 0, 1);   // JALR
        add_vec(0, BUB, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, BUB, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, BUB, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, ld_i(3, 1),      0, 0, 0, 0, 0, 0, 0);
        add_vec(1, alu_i(4, 3, 0),  0, 0, 0, 0, 0, 1, 0);   // stall seen, rst asserted
        add_vec(0, alu_i(4, 3, 0),  0, 0, 0, 0, 0, 0, 0);   // all stages bubbles
        add_vec(0, BUB, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, BUB, 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].d, vecs[i].r, vecs[i].z, vecs[i].l);
            sample(1);
            check($sformatf("vec%0d", i),
                  64'({bus.PCSrcE, bus.forwardAE, bus.forwardBE, bus.stallF, bus.stallD, bus.flushD}),
                  64'({vecs[i].pc, vecs[i].fa, vecs[i].fb, vecs[i].st, vecs[i].st, vecs[i].fd}));
            advance();
        end

        // Random run; D is held on a stall and bubbled after a flushD, as the datapath would.
        d = BUB;
        last_stall = 1'b0;
        last_fd    = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 99) == 0);
            if (last_fd) d = BUB;
            else if (!last_stall) d = rand_instr();
            apply(d, r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            sample(1);
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
